// File: rtl/aibio_hvmadc_seq_cbb.sv
// aibio_hvmadc_seq_cbb -- sequenced HV monitor ADC behavioural model.
// Scans the channels set in chan_mask (single pass or continuous) and
// averages 1/2/4/8 conversions per result. Each result is published with
// its channel tag, and an end-of-pass strobe follows the last channel.
// Optional feature macro: AIBIO_HVMADC_THRESH_EN adds thr_hi, alarm_clr and
// a sticky per-channel over-threshold alarm output.
module aibio_hvmadc_seq_cbb #(
    parameter int  NCH         = 8,
    parameter int  NBITS       = 10,
    parameter int  CONV_CYCLES = 16,
    parameter real VREF        = 0.85
) (
    input  logic                   adcclk,
    input  logic                   reset_n,
    input  logic                   adc_en,
    input  logic [1:0]             clkdiv,
    input  real                    adc_anain [NCH],
    input  logic [NCH-1:0]         chan_mask,
    input  logic                   scan_mode,
    input  logic [1:0]             avg_sel,
    input  logic                   adc_start,
    input  logic                   adc_stop,
`ifdef AIBIO_HVMADC_THRESH_EN
    input  logic [NBITS-1:0]       thr_hi,
    input  logic                   alarm_clr,
    output logic [NCH-1:0]         alarm,
`endif
    output logic [NBITS-1:0]       adcout,
    output logic [$clog2(NCH)-1:0] adcout_ch,
    output logic                   adcdone,
    output logic                   scan_done,
    output logic                   adc_busy
);
    localparam int  CHW = $clog2(NCH);
    localparam int  AW  = NBITS + 3;
    localparam int  TKW = $clog2(CONV_CYCLES);
    localparam real FS  = real'(32'd1 << NBITS);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_CONVERT = 3'd2;
    localparam logic [2:0] ST_RESULT  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Quantise one analog sample: floor(v/VREF*2^NBITS), clamped to the code range.
    function automatic logic [NBITS-1:0] adc_code(input real v);
        int ci;
        if (v >= VREF) begin
            ci = (32'sd1 <<< NBITS) - 32'sd1;
        end else if (v < 0.0) begin
            ci = 32'sd0;
        end else begin
            ci = $rtoi(v / VREF * FS);
            if (ci > (32'sd1 <<< NBITS) - 32'sd1) begin
                ci = (32'sd1 <<< NBITS) - 32'sd1;
            end else begin
                ci = ci;
            end
        end
        return NBITS'(ci);
    endfunction

    // Tick divider factor selected by clkdiv.
    function automatic logic [4:0] div_decode(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'd4;
            2'b01:   return 5'd8;
            2'b10:   return 5'd2;
            2'b11:   return 5'd16;
            default: return 5'd4;
        endcase
    endfunction

    // Index of the lowest set bit of m (0 when m is empty).
    function automatic logic [CHW-1:0] lowest_bit(input logic [NCH-1:0] m);
        logic [CHW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = CHW'(i);
            else      r = r;
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit of m strictly above p.
    function automatic logic [CHW:0] next_above(input logic [NCH-1:0] m, input logic [CHW-1:0] p);
        logic [CHW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(p))) r = {1'b1, CHW'(i)};
            else                       r = r;
        end
        return r;
    endfunction

    logic [2:0]       state_q, state_d;
    logic             start_prev_q;
    logic [CHW-1:0]   ptr_q, ptr_d;
    logic [1:0]       avg_q, avg_d;
    logic [4:0]       div_q, div_d;
    logic [3:0]       pre_q, pre_d;
    logic [TKW-1:0]   tk_q, tk_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [NBITS-1:0] code_q, code_d;
    logic [NBITS-1:0] adcout_q, adcout_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic             done_q, done_d;
    logic             sdone_q, sdone_d;
    logic             busy_q, busy_d;

    logic             start_edge_s;
    logic             last_tick_s;
    logic             enter_s;
    logic [AW-1:0]    acc_sum_s;
    logic [3:0]       cnt_inc_s;
    logic [CHW:0]     nxt_s;

    // Next-state logic: scan sequencing, conversion timing, accumulation and publishing.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        avg_d    = avg_q;
        div_d    = div_q;
        pre_d    = pre_q;
        tk_d     = tk_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        code_d   = code_q;
        adcout_d = adcout_q;
        ch_d     = ch_q;
        done_d   = 1'b0;
        sdone_d  = 1'b0;
        enter_s  = 1'b0;

        start_edge_s = adc_start & ~start_prev_q;
        acc_sum_s    = acc_q + AW'(code_q);
        cnt_inc_s    = cnt_q + 4'd1;
        nxt_s        = next_above(chan_mask, ptr_q);
        last_tick_s  = ({1'b0, pre_q} == (div_q - 5'd1)) && (tk_q == TKW'(CONV_CYCLES - 1));

        if (adc_stop || !adc_en) begin
            // Abort wins over everything, including a result due on this edge.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_edge_s && (chan_mask != '0)) begin
                        state_d = ST_SELECT;
                        ptr_d   = lowest_bit(chan_mask);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    avg_d   = avg_sel;
                    state_d = ST_CONVERT;
                    enter_s = 1'b1;
                end
                ST_CONVERT: begin
                    if (last_tick_s) begin
                        acc_d = acc_sum_s;
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s < (4'd1 << avg_q)) begin
                            state_d = ST_CONVERT;
                            enter_s = 1'b1;
                        end else begin
                            state_d  = ST_RESULT;
                            adcout_d = NBITS'(acc_sum_s >> avg_q);
                            ch_d     = ptr_q;
                            done_d   = 1'b1;
                        end
                    end else if ({1'b0, pre_q} == (div_q - 5'd1)) begin
                        pre_d = 4'd0;
                        tk_d  = tk_q + TKW'(1);
                    end else begin
                        pre_d = pre_q + 4'd1;
                    end
                end
                ST_RESULT: begin
                    if (chan_mask == '0) begin
                        state_d = ST_IDLE;
                    end else if (nxt_s[CHW]) begin
                        ptr_d   = nxt_s[CHW-1:0];
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_DONE;
                        sdone_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (scan_mode && (chan_mask != '0)) begin
                        ptr_d   = lowest_bit(chan_mask);
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Every CONVERT entry restarts the tick count, latches the divider and samples the input.
        if (enter_s) begin
            pre_d  = 4'd0;
            tk_d   = '0;
            div_d  = div_decode(clkdiv);
            code_d = adc_code(adc_anain[ptr_q]);
        end else begin
            code_d = code_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces all outputs to zero at once.
    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            ptr_q        <= '0;
            avg_q        <= 2'd0;
            div_q        <= 5'd4;
            pre_q        <= 4'd0;
            tk_q         <= '0;
            cnt_q        <= 4'd0;
            acc_q        <= '0;
            code_q       <= '0;
            adcout_q     <= '0;
            ch_q         <= '0;
            done_q       <= 1'b0;
            sdone_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= adc_start;
            ptr_q        <= ptr_d;
            avg_q        <= avg_d;
            div_q        <= div_d;
            pre_q        <= pre_d;
            tk_q         <= tk_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            code_q       <= code_d;
            adcout_q     <= adcout_d;
            ch_q         <= ch_d;
            done_q       <= done_d;
            sdone_q      <= sdone_d;
            busy_q       <= busy_d;
        end
    end

`ifdef AIBIO_HVMADC_THRESH_EN
    logic [NCH-1:0] alarm_q, alarm_d, alarm_set_s;

    // Sticky alarm: a new over-threshold result beats a coincident clear.
    always_comb begin
        if (done_d && (adcout_d > thr_hi)) begin
            alarm_set_s = {{(NCH-1){1'b0}}, 1'b1} << ptr_q;
        end else begin
            alarm_set_s = '0;
        end
        if (alarm_clr) begin
            alarm_d = alarm_set_s;
        end else begin
            alarm_d = alarm_q | alarm_set_s;
        end
    end

    // Alarm register.
    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q <= '0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

    assign adcout    = adcout_q;
    assign adcout_ch = ch_q;
    assign adcdone   = done_q;
    assign scan_done = sdone_q;
    assign adc_busy  = busy_q;

endmodule
